// File: rtl/speed_pkg.sv
// Shared encodings for the speed-level counter: FSM states and step directions.
package speed_pkg;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } speed_state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..DIV-1 counter; PULSE marks the cycle whose edge wraps it to 0.
module tick_prescaler #(
  parameter int DIV = 1000
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic CLR,
  input  logic EN,
  output logic PULSE
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (CLR) begin
      cnt_d = '0;
    end else if (EN) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
    end
  end

  // A clear wins over the terminal count so a phase reset never emits a stray pulse.
  assign PULSE = EN && !CLR && (cnt_q == TERM);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/speed_level_counter.sv
// Bounded speed level driven by step commands, with a rate TICK whose period
// is BASE_DIV * (MAX_LEVEL + 1 - LEVEL) cycles while the level is above MIN_LEVEL.
module speed_level_counter
  import speed_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MIN_LEVEL = 0,
  parameter int MAX_LEVEL = 15,
  parameter int BASE_DIV  = 1000,
  parameter int SATURATE  = 1
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             ENABLE,
  input  logic             UP_DOWN,
  output logic [WIDTH-1:0] LEVEL,
  output logic             AT_MAX,
  output logic             AT_MIN,
  output logic             CHANGED,
  output logic             LIMIT_HIT,
  output logic             TICK
);

  localparam int LW = WIDTH + 1;
  localparam logic [LW-1:0] MIN_X = LW'(MIN_LEVEL);
  localparam logic [LW-1:0] MAX_X = LW'(MAX_LEVEL);

  logic [WIDTH-1:0] level_q, level_d;
  logic             changed_q, changed_d;
  logic             limit_hit_q, limit_hit_d;
  logic             tick_q, tick_d;
  logic [LW-1:0]    div_q, div_d;
  speed_state_e     state_q, state_d;

  logic [LW-1:0] level_x;
  logic [LW-1:0] up_x;
  logic [LW-1:0] dn_x;
  logic [LW-1:0] div_last;
  logic          run_en;
  logic          clr;
  logic          base_pulse;

  assign level_x  = {1'b0, level_q};
  assign up_x     = level_x + LW'(1);
  assign dn_x     = level_x - LW'(1);
  // Reload R = MAX+1-LEVEL base pulses, so the divider's last count is R-1.
  assign div_last = MAX_X - level_x;

  always_comb begin
    level_d     = level_q;
    limit_hit_d = 1'b0;
    if (ENABLE) begin
      if (UP_DOWN == DIR_UP) begin
        if (level_x >= MAX_X) begin
          if (SATURATE != 0) limit_hit_d = 1'b1;
          else               level_d     = WIDTH'(MIN_LEVEL);
        end else begin
          level_d = up_x[WIDTH-1:0];
        end
      end else begin
        if (level_x <= MIN_X) begin
          if (SATURATE != 0) limit_hit_d = 1'b1;
          else               level_d     = WIDTH'(MAX_LEVEL);
        end else begin
          level_d = dn_x[WIDTH-1:0];
        end
      end
    end
    changed_d = (level_d != level_q);
  end

  always_comb begin
    state_d = state_q;
    run_en  = 1'b0;
    case (state_q)
      ST_STOPPED: begin
        if ({1'b0, level_d} != MIN_X) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        run_en = 1'b1;
        if ({1'b0, level_d} == MIN_X) state_d = ST_STOPPED;
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  // Any level change restarts the rate phase; stopped keeps everything parked at 0.
  assign clr = changed_d || !run_en;

  tick_prescaler #(
    .DIV (BASE_DIV)
  ) u_prescaler (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .CLR   (clr),
    .EN    (run_en),
    .PULSE (base_pulse)
  );

  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    if (clr) begin
      div_d = '0;
    end else if (base_pulse) begin
      if (div_q >= div_last) begin
        div_d  = '0;
        tick_d = 1'b1;
      end else begin
        div_d = div_q + LW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      level_q     <= WIDTH'(MIN_LEVEL);
      changed_q   <= 1'b0;
      limit_hit_q <= 1'b0;
      tick_q      <= 1'b0;
      div_q       <= '0;
      state_q     <= ST_STOPPED;
    end else begin
      level_q     <= level_d;
      changed_q   <= changed_d;
      limit_hit_q <= limit_hit_d;
      tick_q      <= tick_d;
      div_q       <= div_d;
      state_q     <= state_d;
    end
  end

  assign LEVEL     = level_q;
  assign AT_MAX    = ({1'b0, level_q} == MAX_X);
  assign AT_MIN    = ({1'b0, level_q} == MIN_X);
  assign CHANGED   = changed_q;
  assign LIMIT_HIT = limit_hit_q;
  assign TICK      = tick_q;

endmodule

// File: tb/tb_speed_level_counter.sv
// Two DUTs (saturating and wrapping) share one stimulus stream and are checked
// every cycle against an elapsed-time model, plus directed literal expectations.
module tb_speed_level_counter;

  localparam int WIDTH = 2;
  localparam int MINL  = 0;
  localparam int MAXL  = 3;
  localparam int DIV   = 4;

  logic CLK     = 1'b0;
  logic RSTn    = 1'b0;
  logic ENABLE  = 1'b0;
  logic UP_DOWN = 1'b0;

  logic [WIDTH-1:0] lvl [2];
  logic at_max [2];
  logic at_min [2];
  logic chg    [2];
  logic lim    [2];
  logic tick   [2];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: level plus cycles elapsed since the last phase reset.
  int m_level [2] = '{MINL, MINL};
  int m_phase [2] = '{0, 0};
  int m_tick  [2] = '{0, 0};
  int m_chg   [2] = '{0, 0};
  int m_lim   [2] = '{0, 0};

  always #5 CLK = ~CLK;

  speed_level_counter #(
    .WIDTH(WIDTH), .MIN_LEVEL(MINL), .MAX_LEVEL(MAXL), .BASE_DIV(DIV), .SATURATE(1)
  ) u_sat (
    .CLK(CLK), .RSTn(RSTn), .ENABLE(ENABLE), .UP_DOWN(UP_DOWN),
    .LEVEL(lvl[0]), .AT_MAX(at_max[0]), .AT_MIN(at_min[0]),
    .CHANGED(chg[0]), .LIMIT_HIT(lim[0]), .TICK(tick[0])
  );

  speed_level_counter #(
    .WIDTH(WIDTH), .MIN_LEVEL(MINL), .MAX_LEVEL(MAXL), .BASE_DIV(DIV), .SATURATE(0)
  ) u_wrap (
    .CLK(CLK), .RSTn(RSTn), .ENABLE(ENABLE), .UP_DOWN(UP_DOWN),
    .LEVEL(lvl[1]), .AT_MAX(at_max[1]), .AT_MIN(at_min[1]),
    .CHANGED(chg[1]), .LIMIT_HIT(lim[1]), .TICK(tick[1])
  );

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, idx, $time, act, exp);
    end
  endtask

  // Reference model, updated on each edge or asynchronous reset.
  initial begin
    forever begin
      @(posedge CLK or negedge RSTn);
      for (int i = 0; i < 2; i++) begin
        if (!RSTn) begin
          m_level[i] = MINL; m_phase[i] = 0; m_tick[i] = 0; m_chg[i] = 0; m_lim[i] = 0;
        end else begin
          int nl;
          nl = m_level[i];
          m_lim[i] = 0;
          if (ENABLE) begin
            if (UP_DOWN == 1'b0) begin
              if (m_level[i] == MAXL) begin
                if (i == 0) m_lim[i] = 1; else nl = MINL;
              end else nl = m_level[i] + 1;
            end else begin
              if (m_level[i] == MINL) begin
                if (i == 0) m_lim[i] = 1; else nl = MAXL;
              end else nl = m_level[i] - 1;
            end
          end
          m_chg[i] = (nl != m_level[i]) ? 1 : 0;
          if (m_chg[i] != 0 || nl == MINL) begin
            m_phase[i] = 0;
            m_tick[i]  = 0;
          end else begin
            m_phase[i]++;
            m_tick[i] = (m_phase[i] % (DIV * (MAXL + 1 - nl)) == 0) ? 1 : 0;
          end
          m_level[i] = nl;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        chk("level",     i, 8'(lvl[i]),    8'(m_level[i]));
        chk("at_max",    i, 8'(at_max[i]), 8'(m_level[i] == MAXL));
        chk("at_min",    i, 8'(at_min[i]), 8'(m_level[i] == MINL));
        chk("changed",   i, 8'(chg[i]),    8'(m_chg[i]));
        chk("limit_hit", i, 8'(lim[i]),    8'(m_lim[i]));
        chk("tick",      i, 8'(tick[i]),   8'(m_tick[i]));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic step(input logic dir);
    ENABLE  = 1'b1;
    UP_DOWN = dir;
    @(posedge CLK);
    #1;
    ENABLE  = 1'b0;
    $display("step dir=%0d -> sat level=%0d wrap level=%0d", dir, lvl[0], lvl[1]);
  endtask

  // Cycles until TICK on instance idx, or -1 if none within max_cyc.
  task automatic wait_tick(input int idx, input int max_cyc, output int cyc);
    cyc = -1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge CLK);
      #1;
      if (tick[idx] === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic count_ticks(input int idx, input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(posedge CLK);
      #1;
      if (tick[idx] === 1'b1) cnt++;
    end
  endtask

  initial begin
    int c;
    idle(3);
    RSTn = 1'b1;

    count_ticks(0, 50, c);
    chk("idle_ticks", 0, 8'(c), 8'd0);
    chk("idle_level", 0, 8'(lvl[0]), 8'd0);
    chk("idle_at_min", 0, 8'(at_min[0]), 8'd1);

    step(1'b0);
    chk("up1_level", 0, 8'(lvl[0]), 8'd1);
    chk("up1_changed", 0, 8'(chg[0]), 8'd1);
    wait_tick(0, 40, c);
    chk("first_tick_l1", 0, 8'(c), 8'd12);
    wait_tick(0, 40, c);
    chk("period_l1", 0, 8'(c), 8'd12);

    step(1'b0);
    step(1'b0);
    chk("up3_level", 0, 8'(lvl[0]), 8'd3);
    chk("up3_at_max", 0, 8'(at_max[0]), 8'd1);
    step(1'b0);
    chk("sat_hold_level", 0, 8'(lvl[0]), 8'd3);
    chk("sat_limit_hit", 0, 8'(lim[0]), 8'd1);
    chk("sat_changed", 0, 8'(chg[0]), 8'd0);
    chk("wrap_level", 1, 8'(lvl[1]), 8'd0);
    chk("wrap_changed", 1, 8'(chg[1]), 8'd1);
    chk("wrap_tick", 1, 8'(tick[1]), 8'd0);
    wait_tick(0, 20, c);
    wait_tick(0, 20, c);
    chk("period_l3", 0, 8'(c), 8'd4);

    step(1'b1);
    chk("wrap_down_level", 1, 8'(lvl[1]), 8'd3);
    chk("sat_down_level", 0, 8'(lvl[0]), 8'd2);

    step(1'b1);
    idle(6);
    step(1'b1);
    chk("stop_level", 0, 8'(lvl[0]), 8'd0);
    count_ticks(0, 20, c);
    chk("stop_ticks", 0, 8'(c), 8'd0);
    step(1'b0);
    wait_tick(0, 40, c);
    chk("restart_tick", 0, 8'(c), 8'd12);

    step(1'b0);
    idle(3);
    RSTn = 1'b0;
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    chk("rst_level", 0, 8'(lvl[0]), 8'd0);
    chk("rst_tick", 0, 8'(tick[0]), 8'd0);
    chk("rst_level", 1, 8'(lvl[1]), 8'd0);
    count_ticks(0, 30, c);
    chk("rst_no_tick", 0, 8'(c), 8'd0);

    for (int k = 0; k < 3000; k++) begin
      ENABLE  = ($urandom_range(0, 7) == 0);
      UP_DOWN = $urandom_range(0, 2) == 0;
      RSTn    = ($urandom_range(0, 599) != 0);
      @(posedge CLK);
      #1;
      if (ENABLE || !RSTn)
        $display("rand k=%0d en=%0d dir=%0d rstn=%0d -> sat=%0d wrap=%0d",
                 k, ENABLE, UP_DOWN, RSTn, lvl[0], lvl[1]);
    end
    ENABLE = 1'b0;
    RSTn   = 1'b1;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
